// File: rtl/truth_table_capture.sv
`timescale 1ns/1ps
// Truth-table scanner: steps a 4-input function block through every input
// vector, samples its output F after a settle delay and builds the table plus a minterm count.
module truth_table_capture #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [WIDTH-1:0]        abcd,
  input  logic                    f_in,
  output logic                    busy,
  output logic                    done,
  output logic [(1<<WIDTH)-1:0]   truth_table,
  output logic [WIDTH:0]          ones,
  output logic [1:0]              fsm_state
);

  localparam int              N      = 1 << WIDTH;
  localparam logic [WIDTH-1:0] LAST  = WIDTH'(N - 1);
  localparam logic [3:0]      SC_END = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] idx;
  logic [3:0]       sc;
  logic             sample_now;
  logic             last_vec;

  // start is a level request sampled only in IDLE; there is no ready/ack,
  // a pulse seen in HOLD or DONE is simply dropped.
  assign sample_now = (state == HOLD) && (sc == SC_END);
  assign last_vec   = (idx == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = HOLD;
      HOLD:    if (sample_now && last_vec) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      sc          <= '0;
      truth_table <= '0;
      ones        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx         <= '0;
            sc          <= '0;
            truth_table <= '0;
            ones        <= '0;
          end
        end
        HOLD: begin
          if (sample_now) begin
            truth_table[idx] <= f_in;
            ones             <= ones + (WIDTH+1)'(f_in);
            // idx stays at the last vector on the terminal sample, never wrapping
            if (!last_vec) begin
              idx <= idx + 1'b1;
              sc  <= '0;
            end
          end else begin
            sc <= sc + 4'd1;
          end
        end
        DONE: begin
          idx <= '0;
          sc  <= '0;
        end
        default: begin
          idx <= '0;
          sc  <= '0;
        end
      endcase
    end
  end

  assign busy      = (state == HOLD);
  assign done      = (state == DONE);
  assign abcd      = (state == HOLD) ? idx : '0;
  assign fsm_state = state;

endmodule

// File: tb/tb_truth_table_capture.sv
`timescale 1ns/1ps
// Directed bench for truth_table_capture: closed loop with exam1, function
// variants, start-while-busy, asynchronous reset and a SETTLE=0 instance.
module tb_truth_table_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start0;
  logic [1:0]  f_sel;
  logic [3:0]  abcd1, abcd0;
  logic        f1, f0;
  logic        busy1, busy0, done1, done0;
  logic [15:0] tt1, tt0;
  logic [4:0]  ones1, ones0;
  logic [1:0]  st1, st0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  function automatic logic exam1(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return (a & b | ~c & ~d) & (a & ~b | c & d) & (a & ~c | d & ~b);
  endfunction

  always_comb begin
    case (f_sel)
      2'd0:    f1 = exam1(abcd1);
      2'd1:    f1 = 1'b1;
      2'd2:    f1 = abcd1[0];
      default: f1 = 1'b0;
    endcase
  end
  assign f0 = exam1(abcd0);

  truth_table_capture #(.WIDTH(4), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start1), .abcd(abcd1), .f_in(f1),
    .busy(busy1), .done(done1), .truth_table(tt1), .ones(ones1), .fsm_state(st1)
  );

  truth_table_capture #(.WIDTH(4), .SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abcd(abcd0), .f_in(f0),
    .busy(busy0), .done(done0), .truth_table(tt0), .ones(ones0), .fsm_state(st0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One scan on the chosen instance; start issued in the first negedge cycle (cycle 0).
  task automatic run_scan(input bit which, input int settle, input logic [1:0] sel,
                          input logic [15:0] exp_tab, input logic [4:0] exp_ones,
                          input int pulse_a, input int pulse_b, input bit chk_clear);
    int hold_cycles;
    int done_cyc;
    int n_done;
    int first_done;
    int seq_bad;
    int exp_a;
    logic       exp_busy;
    logic [3:0] a;
    logic       b, d;
    logic [15:0] t;
    logic [4:0]  o;
    hold_cycles = 16 * (settle + 1);
    done_cyc    = hold_cycles + 1;
    n_done      = 0;
    first_done  = -1;
    seq_bad     = 0;
    f_sel       = sel;
    @(negedge clk);
    check("idle_busy", which ? busy1 : busy0, 0);
    if (which) start1 = 1'b1; else start0 = 1'b1;
    for (int c = 1; c <= done_cyc; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      start0 = 1'b0;
      if (which) begin a = abcd1; b = busy1; d = done1; t = tt1; o = ones1; end
      else       begin a = abcd0; b = busy0; d = done0; t = tt0; o = ones0; end
      exp_busy = (c <= hold_cycles);
      exp_a    = exp_busy ? (c - 1) / (settle + 1) : 0;
      if (b !== exp_busy || a !== 4'(exp_a)) seq_bad++;
      if (d === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = c;
      end
      if (chk_clear && c == 1) check("table_cleared", 32'(t), 0);
      if (c == done_cyc) begin
        check("table", 32'(t), 32'(exp_tab));
        check("ones", 32'(o), 32'(exp_ones));
      end
      if (c == pulse_a || c == pulse_b) begin
        if (which) start1 = 1'b1; else start0 = 1'b1;
      end
    end
    check("abcd_busy_seq", seq_bad, 0);
    check("done_count", n_done, 1);
    check("done_cycle", first_done, done_cyc);
  endtask

  initial begin
    int stray;
    rst    = 1'b1;
    start1 = 1'b0;
    start0 = 1'b0;
    f_sel  = 2'd0;
    #1;
    check("rst_abcd", abcd1, 0);
    check("rst_busy", busy1, 0);
    check("rst_done", done1, 0);
    check("rst_table", tt1, 0);
    check("rst_ones", ones1, 0);
    check("rst_state", st1, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_scan(1, 1, 2'd0, 16'h0100, 5'd1,  -1, -1, 0);
    run_scan(1, 1, 2'd1, 16'hFFFF, 5'd16, -1, -1, 0);
    run_scan(1, 1, 2'd2, 16'hAAAA, 5'd8,  -1, -1, 0);
    run_scan(1, 1, 2'd3, 16'h0000, 5'd0,  -1, -1, 1);

    // extra starts at cycles 10 and 33 ignored; next scan starts in cycle 34
    run_scan(1, 1, 2'd1, 16'hFFFF, 5'd16, 10, 33, 0);
    run_scan(1, 1, 2'd0, 16'h0100, 5'd1,  -1, -1, 1);

    // abort a scan with an asynchronous mid-cycle reset in cycle 15
    f_sel = 2'd1;
    @(negedge clk);
    start1 = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start1 = 1'b0;
    end
    check("ones_pre_reset", ones1, 7);
    rst = 1'b1;
    #1;
    check("abort_abcd", abcd1, 0);
    check("abort_busy", busy1, 0);
    check("abort_done", done1, 0);
    check("abort_table", tt1, 0);
    check("abort_ones", ones1, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done1 !== 1'b0 || busy1 !== 1'b0) stray++;
    end
    check("no_done_after_abort", stray, 0);
    run_scan(1, 1, 2'd0, 16'h0100, 5'd1, -1, -1, 0);

    run_scan(0, 0, 2'd0, 16'h0100, 5'd1, -1, -1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/truth_table_capture.md
# truth_table_capture

Sequential truth-table scanner for a 4-input combinational function block such as `exam1`. On `start` it drives every input vector {A,B,C,D} = 0..15 onto the function under test, samples the returned `f_in` after a configurable settle time, and assembles the 16-bit truth table plus a minterm count. It sits directly upstream of the function block as its stimulus source and directly downstream of it as the consumer of its output F.

## Interface
- `WIDTH`, 4: number of function inputs; table has 2^WIDTH entries.
- `SETTLE`, 1: extra hold cycles per vector before sampling; legal range 0..15.

- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `start`  input  1  scan request, accepted only in IDLE.
- `abcd`  output  WIDTH  vector driven to the function block; MSB = A, LSB = D.
- `f_in`  input  1  function output F for the current `abcd`.
- `busy`  output  1  high while a scan is in progress.
- `done`  output  1  one-cycle pulse when the table is complete.
- `table`  output  2^WIDTH  bit k = sampled F for vector k.
- `ones`  output  WIDTH+1  number of 1 bits in `table`.

## Operation
- Reset value of every output is 0. The FSM enters IDLE and the internal vector and settle counters clear.
- FSM states:
  - IDLE: `busy`=0, `abcd`=0. `start`=1 moves to HOLD, clears `table`, `ones`, vector index `idx` and settle counter `sc`.
  - HOLD: `busy`=1, `abcd`=`idx`. `sc` counts 0..SETTLE.
    - When `sc`==SETTLE, `f_in` is written to `table[idx]`, and `ones` increments if `f_in`=1.
    - If `idx`==2^WIDTH-1, go to DONE. Otherwise `idx`+1, `sc`=0, stay in HOLD.
  - DONE: `busy`=0, `done`=1 for exactly one cycle, `abcd` returns to 0. Always goes to IDLE next.
- `start` in HOLD or DONE is ignored; there is no queuing.
- `table` and `ones` hold their final values from DONE until the next accepted `start`.
- Width rules:
  - `idx` is WIDTH bits and never wraps inside a scan; the terminal test ends the scan.
  - `ones` is WIDTH+1 bits, so it reaches 2^WIDTH without overflow.
  - `sc` is 4 bits.
- `f_in` is treated as combinational from `abcd`. No synchronizer.
- Reset mid-scan: all outputs return to 0 immediately (asynchronous). The partial table is discarded and no `done` is produced.

## Timing
- Cycle 0 is the cycle in which `start`=1 is sampled in IDLE.
- Vector k is driven during cycles 1+k(SETTLE+1) through (k+1)(SETTLE+1).
- `f_in` is sampled at the rising edge that ends the last of those cycles.
- `done` is high in cycle 2^WIDTH·(SETTLE+1)+1:
  - 33 for the defaults.
  - 17 for SETTLE=0.
- `busy` is high from cycle 1 through the last HOLD cycle, and is low in the `done` cycle.
- Earliest next acceptance: `start` in the cycle after DONE. Back-to-back scan period is 2^WIDTH·(SETTLE+1)+2 cycles.
- `table` bit k becomes visible the cycle after it is sampled. `ones` updates the same cycle.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → `abcd`=0, `busy`=0, `done`=0, `table`=16'h0000, `ones`=0 before the next edge.
- Closed loop with `exam1` as the function under test, F=(AB|~C~D)(A~B|CD)(A~C|D~B), SETTLE=1, one-cycle `start` pulse:
  - `abcd` steps 0..15, changing every 2 cycles.
  - `done` is high in cycle 33 only.
  - `table`=16'h0100 (only vector 1000 gives F=1); `ones`=5'd1.
- Function variants:
  - `f_in` tied to 1 → `table`=16'hFFFF, `ones`=5'd16.
  - `f_in`=`abcd[0]` → `table`=16'hAAAA, `ones`=5'd8.
  - `f_in` tied to 0 → `table`=0, `ones`=0.
- Start while busy: extra `start` pulses at cycles 10 and 33 → a single `done` at cycle 33 and no new scan. A `start` at cycle 34 begins a new scan, clears `table` in cycle 35, and `done` follows at cycle 67.
- Reset mid-scan: assert `rst` at cycle 15 for 2 cycles, then `start` → no `done` from the aborted scan. The new scan produces `done` 33 cycles after its start, with the correct `table`=16'h0100.
- SETTLE=0 build: each vector is held 1 cycle, `done` is high in cycle 17, and the `exam1` result is identical (16'h0100, `ones`=1).
